axi_sram_slave: RTL and testbench

- AXI4 slave adapter between one interconnect slave port (S0 IM, S1 DM) and one synchronous single-port SRAM macro.
- Converts AR/R and AW/W/B bursts into SRAM word accesses: CS, OE, byte-active-low WEB, word address, DI and DO.
- One transaction at a time, matching the interconnect's single-address single-data (SASD) model.
- Sits directly downstream of the interconnect; one instance per memory slave.

---
 rtl/axi_sram_slave_pkg.sv | 18 +
 rtl/axi_sram_slave_if.sv | 54 +++++
 rtl/axi_sram_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI4-to-SRAM slave adapter.
package axi_sram_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RFETCH,
        S_RDATA,
        S_WDATA,
        S_WRESP
    } sram_slv_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle between the interconnect slave port and the SRAM adapter.
interface axi_sram_slave_if #(
    parameter int IDS_W = 8
);
    logic [IDS_W-1:0] ARID;
    logic [31:0]      ARADDR;
    logic [3:0]       ARLEN;
    logic [2:0]       ARSIZE;
    logic [1:0]       ARBURST;
    logic             ARVALID;
    logic             ARREADY;

    logic [IDS_W-1:0] RID;
    logic [31:0]      RDATA;
    logic [1:0]       RRESP;
    logic             RLAST;
    logic             RVALID;
    logic             RREADY;

    logic [IDS_W-1:0] AWID;
    logic [31:0]      AWADDR;
    logic [3:0]       AWLEN;
    logic [2:0]       AWSIZE;
    logic [1:0]       AWBURST;
    logic             AWVALID;
    logic             AWREADY;

    logic [31:0]      WDATA;
    logic [3:0]       WSTRB;
    logic             WLAST;
    logic             WVALID;
    logic             WREADY;

    logic [IDS_W-1:0] BID;
    logic [1:0]       BRESP;
    logic             BVALID;
    logic             BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave adapter driving a synchronous single-port SRAM, one burst at a time.
// Optional macro AXI_SRAM_FIXED_BURST_EN: FIXED bursts hold the address for every beat.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int IDS_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    axi_sram_slave_if.slave    bus,
    output logic               CS,
    output logic               OE,
    output logic [3:0]         WEB,
    output logic [SRAM_AW-1:0] A,
    output logic [31:0]        DI,
    input  logic [31:0]        DO
);

    sram_slv_state_t    state_reg, state_next;
    logic [SRAM_AW-1:0] addr_reg, addr_next, next_addr;
    logic [3:0]         cnt_reg, cnt_next;
    logic [3:0]         len_reg, len_next;
    logic [IDS_W-1:0]   id_reg, id_next;

`ifdef AXI_SRAM_FIXED_BURST_EN
    logic [1:0] burst_reg, burst_next;

    assign next_addr = (burst_reg == BURST_FIXED) ? addr_reg : addr_reg + 1'b1;
`else
    assign next_addr = addr_reg + 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            id_reg    <= '0;
`ifdef AXI_SRAM_FIXED_BURST_EN
            burst_reg <= BURST_FIXED;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            id_reg    <= id_next;
`ifdef AXI_SRAM_FIXED_BURST_EN
            burst_reg <= burst_next;
`endif
        end
    end

    assign bus.RID   = id_reg;
    assign bus.RDATA = DO;
    assign bus.RRESP = RESP_OKAY;
    assign bus.BID   = id_reg;
    assign bus.BRESP = RESP_OKAY;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        id_next    = id_reg;
`ifdef AXI_SRAM_FIXED_BURST_EN
        burst_next = burst_reg;
`endif
        bus.ARREADY = 1'b0;
        bus.AWREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RLAST   = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        CS  = 1'b0;
        OE  = 1'b0;
        WEB = 4'hF;
        A   = addr_reg;
        DI  = '0;

        case (state_reg)
            S_IDLE: begin
                // Writes take priority; readies stay low while reset is held.
                bus.AWREADY = !rst;
                bus.ARREADY = !rst && !bus.AWVALID;
                if (bus.AWVALID) begin
                    id_next    = bus.AWID;
                    addr_next  = bus.AWADDR[SRAM_AW+1:2];
                    len_next   = bus.AWLEN;
                    cnt_next   = '0;
`ifdef AXI_SRAM_FIXED_BURST_EN
                    burst_next = bus.AWBURST;
`endif
                    state_next = S_WDATA;
                end else if (bus.ARVALID) begin
                    id_next    = bus.ARID;
                    addr_next  = bus.ARADDR[SRAM_AW+1:2];
                    len_next   = bus.ARLEN;
                    cnt_next   = '0;
`ifdef AXI_SRAM_FIXED_BURST_EN
                    burst_next = bus.ARBURST;
`endif
                    state_next = S_RFETCH;
                end
            end
            S_RFETCH: begin
                CS = 1'b1;
                OE = 1'b1;
                state_next = S_RDATA;
            end
            S_RDATA: begin
                bus.RVALID = 1'b1;
                bus.RLAST  = (cnt_reg == len_reg);
                CS = 1'b1;
                OE = 1'b1;
                // Re-reading the held address keeps DO stable across an RREADY stall.
                if (bus.RREADY) begin
                    A         = next_addr;
                    addr_next = next_addr;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == len_reg)
                        state_next = S_IDLE;
                end
            end
            S_WDATA: begin
                bus.WREADY = 1'b1;
                DI = bus.WDATA;
                if (bus.WVALID) begin
                    CS        = 1'b1;
                    WEB       = ~bus.WSTRB;
                    addr_next = next_addr;
                    cnt_next  = cnt_reg + 1'b1;
                    if (bus.WLAST)
                        state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Size, burst type (when not used) and out-of-range address bits carry no meaning here.
    logic unused_ok;
`ifdef AXI_SRAM_FIXED_BURST_EN
    assign unused_ok = &{1'b0, bus.ARSIZE, bus.AWSIZE,
                         bus.ARADDR[31:SRAM_AW+2], bus.ARADDR[1:0],
                         bus.AWADDR[31:SRAM_AW+2], bus.AWADDR[1:0]};
`else
    assign unused_ok = &{1'b0, bus.ARSIZE, bus.AWSIZE, bus.ARBURST, bus.AWBURST,
                         bus.ARADDR[31:SRAM_AW+2], bus.ARADDR[1:0],
                         bus.AWADDR[31:SRAM_AW+2], bus.AWADDR[1:0]};
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave with a behavioural SRAM; FIXED-burst case under AXI_SRAM_FIXED_BURST_EN.
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int SRAM_AW = 14;
    localparam int IDS_W   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_sram_slave_if #(.IDS_W(IDS_W)) bus ();

    logic               cs, oe;
    logic [3:0]         web;
    logic [SRAM_AW-1:0] a;
    logic [31:0]        di;
    logic [31:0]        sram_do = 32'h0;

    axi_sram_slave #(.SRAM_AW(SRAM_AW), .IDS_W(IDS_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .CS(cs), .OE(oe), .WEB(web), .A(a), .DI(di), .DO(sram_do)
    );

    // SRAM model with a backdoor port for preloading.
    logic [31:0]        mem [0:(1<<SRAM_AW)-1];
    logic               bd_we = 1'b0;
    logic [SRAM_AW-1:0] bd_addr = '0;
    logic [31:0]        bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] = bd_data;
        if (cs && oe) sram_do <= mem[a];
        if (cs) begin
            for (int b = 0; b < 4; b++)
                if (!web[b]) mem[a][b*8 +: 8] = di[b*8 +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [IDS_W-1:0] id;
        logic [31:0]      data;
        logic             last;
    } rbeat_t;

    rbeat_t           r_q[$];
    logic [IDS_W-1:0] b_q[$];
    int               r_pop_cnt = 0;

    // Monitor: compare every presented R/B beat against the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && bus.RVALID) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                check("rdata", bus.RDATA, r_q[0].data);
                check("rid",   bus.RID,   r_q[0].id);
                check("rlast", bus.RLAST, r_q[0].last);
                check("rresp", bus.RRESP, RESP_OKAY);
                if (bus.RREADY) begin
                    void'(r_q.pop_front());
                    r_pop_cnt++;
                end
            end
        end
        if (!rst && bus.BVALID) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else begin
                check("bid",   bus.BID,   b_q[0]);
                check("bresp", bus.BRESP, RESP_OKAY);
                if (bus.BREADY) void'(b_q.pop_front());
            end
        end
    end

    task automatic preload(input logic [SRAM_AW-1:0] wa, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = wa; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        bit done = 1'b0;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
        bus.ARSIZE = 3'd2; bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (bus.ARREADY) done = 1'b1;
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        if (!done) check("ar_timeout", 0, 1);
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst);
        bit done = 1'b0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
        bus.AWSIZE = 3'd2; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (bus.AWREADY) done = 1'b1;
        end
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        if (!done) check("aw_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit done = 1'b0;
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (bus.WREADY) done = 1'b1;
        end
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        if (!done) check("w_timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while ((r_q.size() != 0 || b_q.size() != 0) && k < 100);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int k = 0;
        while (r_pop_cnt < target && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    rbeat_t beat;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;

        preload(14'h0010, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) preload(14'h0040 + 14'(i), 32'hA000_0000 + i);
        for (int i = 0; i < 4; i++) preload(14'h0080 + 14'(i), 32'hB000_0000 + i);
        preload(14'h0002, 32'h11223344);
        preload(14'h0005, 32'h00000000);
        preload(14'h3FFF, 32'h00000000);
        preload(14'h0000, 32'h00000000);
        preload(14'h0030, 32'h00000000);
        preload(14'h0031, 32'h00000000);
        preload(14'h0032, 32'h00000000);

        // Reset-state outputs
        @(negedge clk);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready",  bus.WREADY,  0);
        check("rst_rvalid",  bus.RVALID,  0);
        check("rst_bvalid",  bus.BVALID,  0);
        check("rst_cs_oe",   {cs, oe},    2'b00);
        check("rst_web",     web,         4'hF);
        check("rst_a",       a,           0);
        check("rst_di",      di,          0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {bus.AWREADY, bus.ARREADY}, 2'b11);
        @(posedge clk); #1;

        // Single read with latency check
        beat = '{id: 8'h12, data: 32'hDEADBEEF, last: 1'b1};
        r_q.push_back(beat);
        ar_send(8'h12, 32'h40, 4'd0);
        @(negedge clk);
        check("rfetch_rvalid", bus.RVALID, 0);
        @(negedge clk);
        check("r_latency_rvalid", bus.RVALID, 1);
        drain();

        // INCR read of 4 beats with a 3-cycle stall on beat 2
        for (int i = 0; i < 4; i++) begin
            beat = '{id: 8'h21, data: 32'hA000_0000 + i, last: (i == 3)};
            r_q.push_back(beat);
        end
        ar_send(8'h21, 32'h100, 4'd3);
        wait_pops(r_pop_cnt + 1);
        bus.RREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.RREADY = 1'b1;
        drain();

        // Byte-masked write with BREADY held off
        b_q.push_back(8'h34);
        bus.BREADY = 1'b0;
        aw_send(8'h34, 32'h8, 4'd0, BURST_INCR);
        w_send(32'hAABBCCDD, 4'b0101, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_hold", bus.BVALID, 1);
        end
        @(posedge clk); #1;
        bus.BREADY = 1'b1;
        drain();
        check("byte_write_mem", mem[2], 32'h11BB33DD);

        // Simultaneous AW and AR: write wins, read then returns the new data
        b_q.push_back(8'h56);
        beat = '{id: 8'h78, data: 32'hCAFEF00D, last: 1'b1};
        r_q.push_back(beat);
        fork
            begin
                aw_send(8'h56, 32'h14, 4'd0, BURST_INCR);
                w_send(32'hCAFEF00D, 4'hF, 1'b1);
            end
            ar_send(8'h78, 32'h14, 4'd0);
            begin
                @(negedge clk);
                check("arb_readies", {bus.AWREADY, bus.ARREADY}, 2'b10);
            end
        join
        drain();

        // Write burst wrapping from the top word to word 0, then read it back
        b_q.push_back(8'h9A);
        aw_send(8'h9A, 32'hFFFC, 4'd1, BURST_INCR);
        w_send(32'h01010101, 4'hF, 1'b0);
        w_send(32'h02020202, 4'hF, 1'b1);
        drain();
        check("wrap_mem_top", mem[14'h3FFF], 32'h01010101);
        check("wrap_mem_zero", mem[0], 32'h02020202);
        beat = '{id: 8'h9B, data: 32'h01010101, last: 1'b0};
        r_q.push_back(beat);
        beat = '{id: 8'h9B, data: 32'h02020202, last: 1'b1};
        r_q.push_back(beat);
        ar_send(8'h9B, 32'hFFFC, 4'd1);
        drain();

        // Reset during beat 2 of a 4-beat read
        for (int i = 0; i < 4; i++) begin
            beat = '{id: 8'h44, data: 32'hB000_0000 + i, last: (i == 3)};
            r_q.push_back(beat);
        end
        ar_send(8'h44, 32'h200, 4'd3);
        wait_pops(r_pop_cnt + 1);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", bus.RVALID, 0);
        check("midrst_cs_oe", {cs, oe}, 2'b00);
        r_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        beat = '{id: 8'h45, data: 32'hDEADBEEF, last: 1'b1};
        r_q.push_back(beat);
        ar_send(8'h45, 32'h40, 4'd0);
        drain();

`ifdef AXI_SRAM_FIXED_BURST_EN
        // FIXED write burst: all beats hit one word, last one sticks
        b_q.push_back(8'hF1);
        aw_send(8'hF1, 32'hC0, 4'd2, BURST_FIXED);
        w_send(32'h00000001, 4'hF, 1'b0);
        w_send(32'h00000002, 4'hF, 1'b0);
        w_send(32'h00000003, 4'hF, 1'b1);
        drain();
        check("fixed_mem_addr", mem[14'h0030], 32'h00000003);
        check("fixed_mem_next", mem[14'h0031], 32'h00000000);
`endif

        check("r_queue_empty", r_q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
